// File: rtl/irq_pkg.sv
// Shared types for the interrupt claim front end.
package irq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OFFER = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/prio_enc_n.sv
// Lowest-index-first priority encoder: cand -> index of lowest set bit plus any-set flag.
module prio_enc_n #(
  parameter int N = 4
) (
  input  logic [2**N-1:0] cand,
  output logic [N-1:0]    sel,
  output logic            any
);

  always_comb begin
    // NOTE: defaults first so every path assigns sel/any and no latch is inferred.
    sel = '0;
    any = 1'b0;
    // Scan from the top down so the lowest set index is the last (winning) write.
    for (int i = 2**N - 1; i >= 0; i--) begin
      if (cand[i]) begin
        sel = N'(i);
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_claim_arbiter.sv
// Edge-detects request lines into pending bits, offers the highest-priority eligible ID
// on a valid/claim handshake and tracks claimed sources until they are completed.
module irq_claim_arbiter
  import irq_pkg::*;
#(
  parameter int N = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [2**N-1:0]   IrqIn,
  input  logic [2**N-1:0]   IrqMask,
  input  logic              Claim,
  input  logic              Complete,
  input  logic [N-1:0]      CompleteId,
  output logic              IdValid,
  output logic [N-1:0]      IdOut,
  output logic [2**N-1:0]   Pending,
  output logic [2**N-1:0]   InService
);

  localparam int W = 2**N;
  localparam logic [W-1:0] ONE = W'(1);

  state_t       state;
  logic [W-1:0] irq_prev;
  logic [W-1:0] edges;
  logic [W-1:0] cand;
  logic [N-1:0] sel;
  logic         any;
  logic         claim_fire;
  logic [W-1:0] claim_oh;
  logic [W-1:0] complete_oh;

  assign edges       = IrqIn & ~irq_prev;
  assign cand        = Pending & IrqMask & ~InService;
  // Only an offered ID can be claimed; Claim outside OFFER is ignored.
  assign claim_fire  = (state == OFFER) && Claim;
  assign claim_oh    = claim_fire ? (ONE << IdOut) : '0;
  assign complete_oh = Complete ? (ONE << CompleteId) : '0;

  prio_enc_n #(.N(N)) u_prio_enc (
    .cand (cand),
    .sel  (sel),
    .any  (any)
  );

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      irq_prev  <= '0;
      Pending   <= '0;
      InService <= '0;
      IdValid   <= 1'b0;
      IdOut     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      irq_prev  <= IrqIn;
      // A fresh edge beats the claim clear; a claim set beats a same-ID complete.
      Pending   <= (Pending & ~claim_oh) | edges;
      InService <= (InService & ~complete_oh) | claim_oh;

      case (state)
        IDLE: begin
          IdValid <= 1'b0;
          if (any) begin
            IdOut   <= sel;
            IdValid <= 1'b1;
            state   <= OFFER;
          end
        end
        OFFER: begin
          if (Claim) begin
            IdValid <= 1'b0;
            state   <= GAP;
          end else if (!any) begin
            IdValid <= 1'b0;
            state   <= IDLE;
          end else begin
            IdOut   <= sel;
          end
        end
        GAP: begin
          IdValid <= 1'b0;
          state   <= IDLE;
        end
        default: begin
          IdValid <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/irq_claim_arbiter.md
Name: irq_claim_arbiter

Overview:
- Interrupt-source front end of the interrupt controller.
- Edge-detects up to 2**N request lines and latches them as pending.
- Selects the highest-priority eligible source and offers its encoded ID on a valid/claim handshake.
- Tracks in-service sources until software completes them. The encoded IDs (IdOut, CompleteId) feed DecN instances downstream, which produce the one-hot clear/set vectors.

Parameters:
- N, 4, ID width in bits; number of sources = 2**N.

Ports:
- Clk  input  1  system clock, rising-edge.
- Rst  input  1  synchronous, active-high reset.
- IrqIn  input  2**N  raw interrupt request lines, synchronous to Clk.
- IrqMask  input  2**N  per-source enable; 1 = eligible.
- Claim  input  1  accepts the offered ID when IdValid=1.
- Complete  input  1  end-of-service strobe.
- CompleteId  input  N  ID being completed.
- IdValid  output  1  an eligible ID is offered.
- IdOut  output  N  offered ID; lowest index = highest priority.
- Pending  output  2**N  latched pending bits.
- InService  output  2**N  claimed, not-yet-completed bits.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high; Clk and Rst are named as listed above.
- Reset values: Pending=0, InService=0, IrqPrev=0, IdValid=0, IdOut=0, state=IDLE.
  - A line that is high at reset release registers an edge on the first post-reset cycle.
  - Rst asserted mid-handshake aborts it; no claim is recorded.
- Edge detect: Edge = IrqIn & ~IrqPrev, with IrqPrev registered every cycle. Edge[i] sets Pending[i] next cycle. Levels that stay high do not re-set the pending bit.
- Eligible vector: Cand = Pending & IrqMask & ~InService. Sel = index of the lowest set bit of Cand.
- Masking: a masked source keeps its Pending bit; unmasking makes it eligible again.
- FSM states:
  - IDLE (IdValid=0): if Cand≠0, register IdOut<=Sel and go to OFFER.
  - OFFER (IdValid=1):
    - IdOut re-registers to Sel each cycle, so a higher-priority arrival preempts the offer.
    - If Cand becomes 0 (for example masked), go to IDLE with IdValid=0.
    - On Claim=1: Pending[IdOut]<=0, InService[IdOut]<=1, go to GAP. The claim acts on the IdOut value visible in that same cycle.
  - GAP (IdValid=0, exactly 1 cycle): lets Pending/InService settle, then go to IDLE.
- Latencies:
  - Edge to IdValid: 2 cycles (edge → Pending → IdOut/IdValid).
  - Back-to-back claims are at most one every 3 cycles.
- Claim while IdValid=0: ignored, no state change.
- Complete: InService[CompleteId]<=0 next cycle. If that bit is already 0, the strobe has no effect.
- Simultaneous events:
  - New edge on source X in the same cycle as the Claim of X: the set wins, so Pending[X] stays 1 and InService[X]=1.
  - Complete of X in the same cycle as the Claim of Y≠X: both take effect.
  - Complete and Claim on the same X cannot both act, because X is not in service while offered; the Claim takes effect.
- Width rules: all indices are N-bit unsigned. CompleteId covers the full range 0..2**N-1, with no out-of-range case.

Decomposition:
- Shared package (irq_pkg): state enum {IDLE, OFFER, GAP}, encoded as 2 bits.
- Sub-module prio_enc_n #(N): Cand (2**N) → Sel (N) plus Any (1); lowest-index-first combinational priority encoder.
- Existing DecN instances provide the one-hot vectors:
  - DecN(IdOut) produces the Pending clear and InService set masks.
  - DecN(CompleteId) produces the InService clear mask.

Test Plan (N=2):
- Reset release with IrqIn=4'b0100, IrqMask=4'hF → Pending=4'b0100 on cycle 1; IdValid=1, IdOut=2 on cycle 2.
- IrqIn edges 4'b1010 in the same cycle, Claim held high → claims ID 1 first, then ID 3 three cycles later; InService=4'b1010, Pending=0.
- Offer of ID 3 is active when an edge arrives on source 0 → IdOut changes to 0 two cycles later, IdValid stays 1; Claim then records ID 0 only.
- IrqMask=4'b1110 with Pending=4'b0001 → IdValid=0. Set IrqMask=4'hF → IdValid=1, IdOut=0 next cycle; Pending[0] retained throughout.
- Claim ID 2, then a new edge on line 2 while in service, then Complete with CompleteId=2 → Pending[2]=1 is held and not offered; after Complete, InService=0, ID 2 is re-offered, and a second claim succeeds.
- Rst pulsed while in OFFER with Claim=1 → Pending=0, InService=0, IdValid=0 next cycle; the claim is lost.
